fp2fix_serial: RTL and testbench

- Multi-cycle converter from IEEE-754 single precision to signed two's-complement fixed point. It is the exit path out of the FP butterfly datapath into fixed-point consumers such as output buffers and DAC/bus formatting.
- Mantissa alignment uses one bit-shift per cycle under a small FSM. Both sides use a valid/ready handshake.
- Result is truncated toward zero and saturated to the output range. Overflow and NaN are flagged.

---
 rtl/fp2fix_serial.sv | 136 +++++++++++++
 tb/tb_fp2fix_serial.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp2fix_serial.sv
// fp2fix_serial: serial IEEE-754 single -> signed Q(WIDTH-FRAC).FRAC converter.
// The mantissa is aligned one bit per cycle. The result truncates toward zero and saturates.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/a on the float side;
//        out_valid/out_ready/z/ovf on the fixed-point side.
module fp2fix_serial #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             ovf
);

   localparam int MW = WIDTH + 24;

   // sh = (E-127) + FRAC - 23 folds into E + (FRAC-150)
   localparam logic signed [9:0] SH_OFF = 10'(FRAC - 150);
   localparam logic signed [9:0] SH_MAX = 10'(WIDTH);
   localparam logic signed [9:0] SH_MIN = -10'sd24;

   localparam logic [MW-1:0] POS_LIM = {{25{1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [MW-1:0] NEG_LIM = POS_LIM + 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_PACK,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [MW-1:0]   r_mag;
   logic [5:0]      r_cnt;
   logic            r_left;
   logic            r_sign;
   logic            r_nan;

   logic [7:0]        w_exp;
   logic [22:0]       w_man;
   logic signed [9:0] w_sh;
   logic [5:0]        w_cnt;
   logic [MW-1:0]     w_m;

   assign w_exp = a[30:23];
   assign w_man = a[22:0];
   assign w_sh  = $signed({2'b00, w_exp}) + SH_OFF;
   assign w_cnt = w_sh[9] ? 6'(10'sd0 - w_sh) : 6'(w_sh);
   assign w_m   = {{WIDTH{1'b0}}, 1'b1, w_man};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         z         <= '0;
         ovf       <= 1'b0;
         r_mag     <= '0;
         r_cnt     <= '0;
         r_left    <= 1'b0;
         r_sign    <= 1'b0;
         r_nan     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  r_sign   <= a[31];
                  r_nan    <= 1'b0;
                  r_left   <= ~w_sh[9];
                  r_cnt    <= w_cnt;
                  r_state  <= S_PACK;
                  // An all-ones magnitude makes PACK saturate by sign.
                  if (w_exp == 8'd0) begin
                     r_mag <= '0;
                  end else if (w_exp == 8'hFF) begin
                     r_mag <= '1;
                     r_nan <= (w_man != 23'd0);
                  end else if (w_sh > SH_MAX) begin
                     r_mag <= '1;
                  end else if (w_sh < SH_MIN) begin
                     r_mag <= '0;
                  end else begin
                     r_mag <= w_m;
                     if (w_sh != 10'sd0) r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
               r_cnt <= r_cnt - 6'd1;
               if (r_cnt == 6'd1) r_state <= S_PACK;
            end
            S_PACK: begin
               if (r_nan) begin
                  z   <= '0;
                  ovf <= 1'b1;
               end else if (!r_sign) begin
                  if (r_mag > POS_LIM) begin
                     z   <= {1'b0, {(WIDTH-1){1'b1}}};
                     ovf <= 1'b1;
                  end else begin
                     z   <= r_mag[WIDTH-1:0];
                     ovf <= 1'b0;
                  end
               end else begin
                  if (r_mag > NEG_LIM) begin
                     z   <= {1'b1, {(WIDTH-1){1'b0}}};
                     ovf <= 1'b1;
                  end else begin
                     // A zero magnitude negates to 0, so no negative zero appears.
                     z   <= WIDTH'(0) - r_mag[WIDTH-1:0];
                     ovf <= 1'b0;
                  end
               end
               out_valid <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp2fix_serial.sv
// tb_fp2fix_serial: directed vectors with a queue scoreboard and an output monitor.
// The bench covers latency, backpressure hold and reset in the middle of an operation.
module tb_fp2fix_serial;

   localparam int W = 16;
   localparam int F = 8;
   localparam int N = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   a;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  z;
   logic          ovf;

   fp2fix_serial #(.WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] z;
      logic         ovf;
      int           lat;
      int           acc;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per result, then checks that it holds.
   bit   seen = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!seen) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got z=%h ovf=%b, required none",
                        z, ovf);
            end else begin
               cur = q.pop_front();
               chk("z", 32'(z), 32'(cur.z));
               chk("ovf", 32'(ovf), 32'(cur.ovf));
               chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
            end
            seen = 1'b1;
         end else begin
            chk("z_hold", 32'(z), 32'(cur.z));
            chk("ovf_hold", 32'(ovf), 32'(cur.ovf));
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic send(input logic [31:0] v, input logic [W-1:0] ez,
                       input logic eo, input int lat, input bit track);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready=0, required 1");
         return;
      end
      a        = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 32'hDEADBEEF;
      if (track) q.push_back('{ez, eo, lat, cyc});
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
         q.delete();
      end
   endtask

   logic [31:0] va[N] = '{
      32'h3F800000, 32'hC0200000, 32'hC3000000, 32'h43480000,
      32'hFF800000, 32'h7FC00000, 32'h2EDBE6FF, 32'h80000000,
      32'h00000001, 32'hBB000000, 32'h47000000, 32'h47800000,
      32'hC7000000, 32'h4F800000, 32'h3F000000, 32'h3F7FFFFF,
      32'hBF7FFFFF
   };
   logic [W-1:0] vz[N] = '{
      16'h0100, 16'hFD80, 16'h8000, 16'h7FFF,
      16'h8000, 16'h0000, 16'h0000, 16'h0000,
      16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF,
      16'h8000, 16'h7FFF, 16'h0080, 16'h00FF,
      16'hFF01
   };
   logic vo[N] = '{
      1'b0, 1'b0, 1'b0, 1'b1,
      1'b1, 1'b1, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b1, 1'b1,
      1'b1, 1'b1, 1'b0, 1'b0,
      1'b0
   };
   int vl[N] = '{
      17, 16, 10, 10,
      2,  2,  2,  2,
      2,  26, 2,  3,
      2,  2,  18, 18,
      18
   };

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < N; i++) send(va[i], vz[i], vo[i], vl[i], 1'b1);
      drain();

      // Backpressure: the result holds and a new request is ignored.
      out_ready = 1'b0;
      send(32'h3F800000, 16'h0100, 1'b0, 17, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         if (i == 3) begin
            a        = 32'h40000000;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      repeat (30) @(negedge clk);

      // Reset in the middle of SHIFT discards the operation.
      send(32'h3F800000, 16'h0100, 1'b0, 17, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_z", 32'(z), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      repeat (30) @(negedge clk);
      send(32'h40000000, 16'h0200, 1'b0, 16, 1'b1);
      drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
